// File: rtl/fft_in_framer.sv
// fft_in_framer: gathers one complex sample per cycle into ping-pong frame
// banks and bursts each complete frame out as LANES-wide vectors for the FFT.
module fft_in_framer #(
    parameter int N_PT      = 512,
    parameter int LANES     = 16,
    parameter int DW        = 9,
    parameter int FRAME_GAP = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_re,
    input  logic signed [DW-1:0] s_im,
    output logic                 valid,
    output logic signed [DW-1:0] dout_re [LANES],
    output logic signed [DW-1:0] dout_im [LANES],
    output logic                 frame_start,
    output logic                 busy
);

    localparam int VECS = N_PT / LANES;
    localparam int AW   = $clog2(N_PT);
    localparam int LW   = $clog2(LANES);
    localparam int VW   = $clog2(VECS);
    localparam int GW   = (FRAME_GAP > 1) ? $clog2(FRAME_GAP + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } stateT;

    // Banks are organised as rows of LANES samples so a whole vector reads in one cycle
    logic signed [DW-1:0] r_memRe [2][VECS][LANES];
    logic signed [DW-1:0] r_memIm [2][VECS][LANES];

    logic [AW-1:0]        r_wrCnt;
    logic                 r_wrBank;
    logic                 r_rdBank;
    logic [1:0]           r_full;
    logic [1:0]           w_fullNext;
    stateT                r_state;
    stateT                w_stateNext;
    logic [VW-1:0]        r_vecCnt;
    logic [VW-1:0]        w_vecNext;
    logic [GW-1:0]        r_gapCnt;
    logic signed [DW-1:0] r_doutRe [LANES];
    logic signed [DW-1:0] r_doutIm [LANES];
    logic                 w_accept;
    logic                 w_frameDone;
    logic                 w_burstDone;

    // Ready depends only on registered flags; it is held low while reset is asserted
    assign s_ready     = rst & ~r_full[r_wrBank];
    assign w_accept    = s_valid & s_ready;
    assign w_frameDone = w_accept && (r_wrCnt == AW'(N_PT - 1));
    assign w_burstDone = (r_state == BURST) && (r_vecCnt == VW'(VECS - 1));
    assign w_vecNext   = (r_state == BURST) ? r_vecCnt + 1'b1 : '0;

    assign dout_re = r_doutRe;
    assign dout_im = r_doutIm;

    // Sample storage; contents are don't-care after reset so it carries no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_memRe[r_wrBank][r_wrCnt[AW-1:LW]][r_wrCnt[LW-1:0]] <= s_re;
            r_memIm[r_wrBank][r_wrCnt[AW-1:LW]][r_wrCnt[LW-1:0]] <= s_im;
        end
    end

    // Write address and bank pointer; the bank flips after the last sample of a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrCnt  <= '0;
            r_wrBank <= 1'b0;
        end else if (w_accept) begin
            if (w_frameDone) begin
                r_wrCnt  <= '0;
                r_wrBank <= ~r_wrBank;
            end else begin
                r_wrCnt <= r_wrCnt + 1'b1;
            end
        end
    end

    // Full flags: writer sets its bank, reader clears its bank; they never target the same bank
    always_comb begin
        w_fullNext = r_full;
        if (w_burstDone) begin
            w_fullNext[r_rdBank] = 1'b0;
        end
        if (w_frameDone) begin
            w_fullNext[r_wrBank] = 1'b1;
        end
    end

    // Register the full flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= '0;
        end else begin
            r_full <= w_fullNext;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Read FSM next state: start on a full bank, burst VECS vectors, optionally rest
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (r_full[r_rdBank]) begin
                    w_stateNext = BURST;
                end
            end
            BURST: begin
                if (r_vecCnt == VW'(VECS - 1)) begin
                    w_stateNext = (FRAME_GAP > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (r_gapCnt == GW'(FRAME_GAP - 1)) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        valid       = (r_state == BURST);
        frame_start = (r_state == BURST) && (r_vecCnt == '0);
        busy        = (|r_full) | (r_state == BURST);
    end

    // Vector counter, gap counter and read bank pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vecCnt <= '0;
            r_gapCnt <= '0;
            r_rdBank <= 1'b0;
        end else begin
            r_vecCnt <= w_vecNext;
            r_gapCnt <= (r_state == GAP) ? r_gapCnt + 1'b1 : '0;
            if (w_burstDone) begin
                r_rdBank <= ~r_rdBank;
            end
        end
    end

    // Output vector register: loads the vector that will be shown in the coming burst cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_doutRe[i] <= '0;
                r_doutIm[i] <= '0;
            end
        end else if (w_stateNext == BURST) begin
            for (int i = 0; i < LANES; i++) begin
                r_doutRe[i] <= r_memRe[r_rdBank][w_vecNext][i];
                r_doutIm[i] <= r_memIm[r_rdBank][w_vecNext][i];
            end
        end
    end

endmodule
